// File: rtl/instruction_encoder_if.sv
// Field-input and memory-write handshake bundle for the instruction encoder.
interface instruction_encoder_if #(
   parameter int unsigned INSTRUCTION_WIDTH      = 16,
   parameter int unsigned ID_WIDTH               = 7,
   parameter int unsigned REGISTER_WIDTH         = 4,
   parameter int unsigned OFFSET_WIDTH           = 12,
   parameter int unsigned BRANCH_CONDITION_WIDTH = 5,
   parameter int unsigned ADDRESS_WIDTH          = 12
);
   logic                              in_valid;
   logic                              in_ready;
   logic [ID_WIDTH-1:0]               ID;
   logic [REGISTER_WIDTH-1:0]         RegD;
   logic [REGISTER_WIDTH-1:0]         RegA;
   logic [REGISTER_WIDTH-1:0]         RegB;
   logic [OFFSET_WIDTH-1:0]           Offset;
   logic [BRANCH_CONDITION_WIDTH-1:0] branch_condition;

   logic                              out_valid;
   logic                              out_ready;
   logic [INSTRUCTION_WIDTH-1:0]      out_word;
   logic [ADDRESS_WIDTH-1:0]          out_address;

   // Producer of decoded fields and consumer of memory writes
   modport master (
      output in_valid, ID, RegD, RegA, RegB, Offset, branch_condition, out_ready,
      input  in_ready, out_valid, out_word, out_address
   );

   // Encoder side
   modport slave (
      input  in_valid, ID, RegD, RegA, RegB, Offset, branch_condition, out_ready,
      output in_ready, out_valid, out_word, out_address
   );
endinterface

// File: rtl/instruction_encoder.sv
// Re-encodes decoded instruction fields into 16-bit ARMAria words and streams them
// as sequential instruction-memory writes, stopping below the OS region.
module instruction_encoder #(
   parameter int unsigned INSTRUCTION_WIDTH      = 16,
   parameter int unsigned ID_WIDTH               = 7,
   parameter int unsigned REGISTER_WIDTH         = 4,
   parameter int unsigned OFFSET_WIDTH           = 12,
   parameter int unsigned BRANCH_CONDITION_WIDTH = 5,
   parameter int unsigned ADDRESS_WIDTH          = 12,
   parameter int unsigned OS_START               = 2048
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_address,
   instruction_encoder_if.slave     bus,
   output logic                     full,
   output logic                     error,
   output logic [ID_WIDTH-1:0]      error_id,
   output logic [ADDRESS_WIDTH-1:0] word_count
);
   localparam int unsigned        AW1      = ADDRESS_WIDTH + 1;
   localparam logic [AW1-1:0]     OS_LIMIT = AW1'(OS_START);

   logic [ADDRESS_WIDTH-1:0]     address;
   logic [AW1-1:0]               address_next_c;
   logic [INSTRUCTION_WIDTH-1:0] enc_word_c;
   logic                         enc_err_c;
   logic [ID_WIDTH-1:0]          rel_c;
   logic [3:0]                   op_c;
   logic [2:0]                   d_c;
   logic [2:0]                   a_c;
   logic [2:0]                   b_c;
   logic [7:0]                   o_c;
   logic [3:0]                   cond_c;
   logic                         accept_c;
   logic                         unused_bits;

   assign d_c    = bus.RegD[2:0];
   assign a_c    = bus.RegA[2:0];
   assign b_c    = bus.RegB[2:0];
   assign o_c    = bus.Offset[7:0];
   assign cond_c = bus.branch_condition[3:0];

   assign unused_bits = ^{bus.RegB[REGISTER_WIDTH-1:3], bus.Offset[OFFSET_WIDTH-1:8],
                          bus.branch_condition[BRANCH_CONDITION_WIDTH-1:4], rel_c[6:5]};

   assign bus.in_ready   = !full && !start && (!bus.out_valid || bus.out_ready);
   assign accept_c       = bus.in_valid && bus.in_ready;
   assign address_next_c = {1'b0, address} + AW1'(1);

   // Field-to-word encoder; rel_c is the ID offset within its group
   always_comb begin
      enc_word_c = '0;
      enc_err_c  = 1'b0;
      rel_c      = '0;
      op_c       = '0;
      case (bus.ID) inside
         7'h01, 7'h02: enc_word_c = {4'h0, bus.ID == 7'h02, o_c[4:0], a_c, d_c};
         7'h03:        enc_word_c = {4'h1, 1'b0, o_c[4:0], a_c, d_c};
         [7'h04:7'h05]: begin
            rel_c      = bus.ID - 7'h04;
            enc_word_c = {4'h1, 1'b1, rel_c[1:0], b_c, a_c, d_c};
         end
         [7'h06:7'h07]: begin
            rel_c      = bus.ID - 7'h04;
            enc_word_c = {4'h1, 1'b1, rel_c[1:0], o_c[2:0], a_c, d_c};
         end
         [7'h08:7'h0b]: begin
            rel_c      = bus.ID - 7'h08;
            op_c       = 4'd2 + rel_c[4:1];
            enc_word_c = {op_c, rel_c[0], d_c, o_c};
         end
         [7'h0c:7'h25]: begin
            rel_c      = bus.ID - 7'h0c;
            enc_word_c = {4'h4, 1'b0, rel_c[4:2], rel_c[1:0], b_c, d_c};
         end
         7'h26: begin
            enc_err_c  = (cond_c == 4'hf);
            enc_word_c = {4'h4, 1'b0, 3'b111, cond_c, 1'b0, b_c};
         end
         7'h27: enc_word_c = {4'h4, 1'b1, d_c, o_c};
         [7'h28:7'h2f]: begin
            rel_c      = bus.ID - 7'h28;
            enc_word_c = {4'h5, rel_c[2:0], b_c, a_c, d_c};
         end
         [7'h30:7'h35]: begin
            rel_c      = bus.ID - 7'h30;
            op_c       = 4'd6 + rel_c[4:1];
            enc_word_c = {op_c, rel_c[0], o_c[4:0], a_c, d_c};
         end
         [7'h36:7'h39]: begin
            rel_c      = bus.ID - 7'h36;
            op_c       = 4'd9 + rel_c[4:1];
            enc_word_c = {op_c, rel_c[0], d_c, o_c};
         end
         7'h3a: enc_word_c = {4'hb, 4'h0, 2'b00, 2'b00, bus.RegD[3:0]};
         [7'h3b:7'h3e]: begin
            rel_c      = bus.ID - 7'h3b;
            enc_word_c = {4'hb, 4'h2, rel_c[1:0], b_c, d_c};
         end
         [7'h3f:7'h42]: begin
            rel_c      = bus.ID - 7'h3f;
            enc_word_c = {4'hb, 4'ha, rel_c[1:0], b_c, d_c};
         end
         7'h43: enc_word_c = {4'hb, 4'h4, 1'b0, 4'h0, d_c};
         7'h44: enc_word_c = {4'hb, 4'hd, 1'b0, 4'h0, d_c};
         7'h45: enc_word_c = {4'hb, 4'he, 2'd0, 3'b000, d_c};
         7'h46: enc_word_c = {4'hb, 4'he, 2'd1, 3'b000, 3'b000};
         7'h47: enc_word_c = {4'hb, 4'he, 2'd2, 3'b000, d_c};
         7'h48: enc_word_c = {4'hc, 4'h0, o_c};
         7'h49: begin
            enc_err_c  = (cond_c == 4'hf);
            enc_word_c = {4'hd, cond_c, o_c};
         end
         [7'h4a:7'h4b]: begin
            rel_c      = bus.ID - 7'h4a;
            enc_word_c = {4'he, rel_c[0], 11'b0};
         end
         7'h4c: enc_word_c = {4'hb, 4'h0, 2'b01, 2'b00, bus.RegA[3:0]};
         7'h4d: enc_word_c = {4'hb, 4'h4, 1'b1, o_c[6:0]};
         7'h4e: enc_word_c = {4'hb, 4'hd, 1'b1, o_c[6:0]};
         7'h64: enc_word_c = 16'hffff;
         default: enc_err_c = 1'b1;
      endcase
   end

   // Write issue, address walk and sticky error capture; start overrides any transfer
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus.out_valid   <= 1'b0;
         bus.out_word    <= '0;
         bus.out_address <= '0;
         address         <= '0;
         word_count      <= '0;
         full            <= 1'b0;
         error           <= 1'b0;
         error_id        <= '0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         if (start) begin
            address    <= base_address;
            word_count <= '0;
            full       <= ({1'b0, base_address} >= OS_LIMIT);
            error      <= 1'b0;
            error_id   <= '0;
         end else if (accept_c) begin
            if (enc_err_c) begin
               error <= 1'b1;
               if (!error) begin
                  error_id <= bus.ID;
               end
            end else begin
               bus.out_valid   <= 1'b1;
               bus.out_word    <= enc_word_c;
               bus.out_address <= address;
               address         <= address_next_c[ADDRESS_WIDTH-1:0];
               word_count      <= word_count + ADDRESS_WIDTH'(1);
               full            <= (address_next_c == OS_LIMIT);
            end
         end else if (bus.in_valid && full) begin
            error <= 1'b1;
            if (!error) begin
               error_id <= bus.ID;
            end
         end
      end
   end
endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: arithmetic reference encoder, random
// fields and back-pressure, directed address/full/error/reset scenarios.
module tb_instruction_encoder;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [11:0] base_address = '0;
   logic        full;
   logic        error;
   logic [6:0]  error_id;
   logic [11:0] word_count;

   instruction_encoder_if bus ();

   instruction_encoder dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .base_address (base_address),
      .bus          (bus.slave),
      .full         (full),
      .error        (error),
      .error_id     (error_id),
      .word_count   (word_count)
   );

   always #5 clock = ~clock;

   typedef struct { int word; int addr; } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad = 0;
   int stall_pct = 0;
   int m_addr = 0;
   int m_count = 0;
   int m_eid = 0;
   bit m_full = 0;
   bit m_err = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int pack_oad(input int op, input int b11, input int o5, input int a, input int d);
      return op * 4096 + b11 * 2048 + o5 * 64 + a * 8 + d;
   endfunction

   function automatic int pack_do(input int op, input int b11, input int d, input int o8);
      return op * 4096 + b11 * 2048 + d * 256 + o8;
   endfunction

   // Reference encoding built from field positions with plain arithmetic
   function automatic int ref_encode(input int id, input int rd, input int ra, input int rb,
                                     input int off, input int cond, output bit err);
      int d, a, b, c, w;
      d = rd % 8; a = ra % 8; b = rb % 8; c = cond % 16; w = 0; err = 0;
      if (id == 1 || id == 2)              w = pack_oad(0, (id == 2) ? 1 : 0, off % 32, a, d);
      else if (id == 3)                    w = pack_oad(1, 0, off % 32, a, d);
      else if (id >= 4 && id <= 5)         w = 'h1800 + (id - 4) * 512 + b * 64 + a * 8 + d;
      else if (id >= 6 && id <= 7)         w = 'h1800 + (id - 4) * 512 + (off % 8) * 64 + a * 8 + d;
      else if (id >= 8 && id <= 'h0b)      w = pack_do(2 + (id - 8) / 2, (id - 8) % 2, d, off % 256);
      else if (id >= 'h0c && id <= 'h25)   w = 'h4000 + ((id - 'h0c) / 4) * 256 + ((id - 'h0c) % 4) * 64 + b * 8 + d;
      else if (id == 'h26) begin err = (c == 15); w = 'h4700 + c * 16 + b; end
      else if (id == 'h27)                 w = pack_do(4, 1, d, off % 256);
      else if (id >= 'h28 && id <= 'h2f)   w = 'h5000 + (id - 'h28) * 512 + b * 64 + a * 8 + d;
      else if (id >= 'h30 && id <= 'h35)   w = pack_oad(6 + (id - 'h30) / 2, (id - 'h30) % 2, off % 32, a, d);
      else if (id >= 'h36 && id <= 'h39)   w = pack_do(9 + (id - 'h36) / 2, (id - 'h36) % 2, d, off % 256);
      else if (id == 'h3a)                 w = 'hB000 + rd % 16;
      else if (id >= 'h3b && id <= 'h3e)   w = 'hB200 + (id - 'h3b) * 64 + b * 8 + d;
      else if (id >= 'h3f && id <= 'h42)   w = 'hBA00 + (id - 'h3f) * 64 + b * 8 + d;
      else if (id == 'h43)                 w = 'hB400 + d;
      else if (id == 'h44)                 w = 'hBD00 + d;
      else if (id >= 'h45 && id <= 'h47)   w = 'hBE00 + (id - 'h45) * 64 + ((id == 'h46) ? 0 : d);
      else if (id == 'h48)                 w = 'hC000 + off % 256;
      else if (id == 'h49) begin err = (c == 15); w = 'hD000 + c * 256 + off % 256; end
      else if (id >= 'h4a && id <= 'h4b)   w = 'hE000 + (id - 'h4a) * 2048;
      else if (id == 'h4c)                 w = 'hB040 + ra % 16;
      else if (id == 'h4d)                 w = 'hB480 + off % 128;
      else if (id == 'h4e)                 w = 'hBD80 + off % 128;
      else if (id == 'h64)                 w = 'hFFFF;
      else err = 1;
      return w;
   endfunction

   task automatic model_error(input int id);
      if (!m_err) m_eid = id;
      m_err = 1;
   endtask

   // Offer one set of fields until accepted or rejected (full); waited counts stalled cycles
   task automatic send(input int id, input int rd, input int ra, input int rb, input int off,
                       input int cond, input int stall_first, output int waited);
      int  w;
      bit  e;
      waited = 0;
      @(negedge clock);
      bus.ID = 7'(id); bus.RegD = 4'(rd); bus.RegA = 4'(ra); bus.RegB = 4'(rb);
      bus.Offset = 12'(off); bus.branch_condition = 5'(cond); bus.in_valid = 1'b1;
      forever begin
         if (waited < stall_first) bus.out_ready = 1'b0;
         else bus.out_ready = ($urandom_range(99) >= stall_pct);
         #1;
         check("in_ready", int'(bus.in_ready), (!m_full && (sb.size() == 0 || bus.out_ready)) ? 1 : 0);
         if (m_full) begin
            model_error(id);
            @(posedge clock);
            return;
         end
         if (bus.in_ready) begin
            w = ref_encode(id, rd, ra, rb, off, cond, e);
            if (e) model_error(id);
            else begin
               sb.push_back('{word: w, addr: m_addr});
               m_addr++;
               m_count++;
               if (m_addr == 2048) m_full = 1;
            end
            @(posedge clock);
            return;
         end
         waited++;
         if (waited > 200) begin
            total++; bad++;
            $display("FAIL send_timeout id=%0h waited=%0d required<=200", id, waited);
            @(posedge clock);
            return;
         end
         @(negedge clock);
      end
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clock);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout pending=%0d required=0", sb.size());
         sb.delete();
      end
      @(negedge clock);
   endtask

   task automatic check_status();
      check("full", int'(full), int'(m_full));
      check("error", int'(error), int'(m_err));
      check("error_id", int'(error_id), m_eid);
      check("word_count", int'(word_count), m_count);
   endtask

   task automatic check_reset_values();
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_word", int'(bus.out_word), 0);
      check("rst_out_address", int'(bus.out_address), 0);
      check("rst_word_count", int'(word_count), 0);
      check("rst_full", int'(full), 0);
      check("rst_error", int'(error), 0);
      check("rst_error_id", int'(error_id), 0);
      check("rst_in_ready", int'(bus.in_ready), 1);
   endtask

   task automatic do_start(input int base);
      @(negedge clock);
      start = 1'b1; base_address = 12'(base); bus.out_ready = 1'b1;
      bus.ID = 7'h64; bus.in_valid = 1'b1;
      #1;
      check("in_ready_start", int'(bus.in_ready), 0);
      @(negedge clock);
      start = 1'b0; bus.in_valid = 1'b0;
      m_addr = base; m_count = 0; m_err = 0; m_eid = 0; m_full = (base >= 2048);
      #1;
      check_status();
   endtask

   // Monitor: pops the scoreboard on every write handshake and checks hold under back-pressure
   initial begin : monitor
      bit   held = 0;
      int   hw = 0;
      int   ha = 0;
      exp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (reset && bus.out_valid) begin
            if (held) begin
               check("hold_word", int'(bus.out_word), hw);
               check("hold_address", int'(bus.out_address), ha);
            end
            if (bus.out_ready) begin
               held = 0;
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_write word=%0h address=%0h required=none",
                           bus.out_word, bus.out_address);
               end else begin
                  e = sb.pop_front();
                  check("out_word", int'(bus.out_word), e.word);
                  check("out_address", int'(bus.out_address), e.addr);
               end
            end else begin
               held = 1;
               hw = int'(bus.out_word);
               ha = int'(bus.out_address);
            end
         end else begin
            held = 0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog elapsed=%0t required=finish", $time);
      $fatal(1, "bench did not finish");
   end

   initial begin : stimulus
      int waited;
      int id;
      int bases[4];
      bases[0] = 'h000; bases[1] = 'h7F0; bases[2] = 'h900; bases[3] = int'($urandom_range(2047));
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.ID = '0; bus.RegD = '0; bus.RegA = '0; bus.RegB = '0; bus.Offset = '0; bus.branch_condition = '0;
      repeat (2) @(negedge clock);
      check_reset_values();
      reset = 1'b1;

      do_start('h010);
      send('h04, 1, 2, 3, 0, 0, 0, waited);
      drain();
      check_status();

      send('h02, 0, 0, 0, 5, 0, 0, waited);
      send('h49, 0, 0, 0, 'h20, 0, 0, waited);
      check("throughput", waited, 0);
      send('h64, 0, 0, 0, 0, 0, 0, waited);
      check("throughput", waited, 0);
      drain();

      send('h27, 5, 0, 0, 'hA5, 0, 0, waited);
      send('h30, 2, 3, 0, 'h1F, 0, 3, waited);
      check("stall_wait", waited, 3);
      drain();
      check_status();

      do_start('h7FE);
      send('h28, 1, 2, 3, 0, 0, 0, waited);
      send('h3a, 9, 0, 0, 0, 0, 0, waited);
      send('h48, 0, 0, 0, 'h33, 0, 0, waited);
      drain();
      check_status();

      do_start('h100);
      send('h50, 1, 1, 1, 1, 1, 0, waited);
      send('h49, 0, 0, 0, 'h10, 15, 0, waited);
      drain();
      check_status();
      send('h03, 4, 5, 0, 'h0A, 0, 0, waited);
      drain();
      check_status();

      send('h0d, 3, 0, 6, 0, 0, 0, waited);
      @(negedge clock);
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      check_reset_values();
      sb.delete();
      m_addr = 0; m_count = 0; m_full = 0; m_err = 0; m_eid = 0;
      @(negedge clock);
      reset = 1'b1;
      do_start('h200);
      send('h4c, 0, 13, 0, 0, 0, 0, waited);
      send('h45, 6, 0, 0, 0, 0, 0, waited);
      drain();
      check_status();

      stall_pct = 30;
      for (int k = 0; k < 4; k++) begin
         do_start(bases[k]);
         for (int n = 0; n < 60; n++) begin
            if ($urandom_range(9) == 0) id = int'($urandom_range(127));
            else begin
               id = int'($urandom_range('h4e));
               if (id == 0) id = 'h64;
            end
            send(id, int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)),
                 int'($urandom_range(4095)), int'($urandom_range(31)), 0, waited);
         end
         drain();
         check_status();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
